// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: iterative CORDIC core doing one micro-rotation per clock (circular/linear/hyperbolic)
// Ports: clk, reset (async, active high); start, mode, vectoring, x_in/y_in/z_in request an operation
// (Q16.16), accepted only in IDLE; x_out/y_out/z_out hold the unscaled results until the next DONE;
// busy is high while iterating, done pulses for one cycle, err flags an unassigned mode code, ovf is
// the sticky signed-overflow flag, built only when CORDIC_OVF_DETECT_EN is defined (else tied to 0).
`ifndef CIRCULAR
`define CIRCULAR 2'd0
`endif
`ifndef LINEAR
`define LINEAR 2'd1
`endif
`ifndef HYPERBOLIC
`define HYPERBOLIC 2'd2
`endif
module cordic_iter_engine #(
    parameter int ITERATIONS = 16,
    parameter int FRAC_BITS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        vectoring,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf
);
    // hyperbolic repeats indices 4 and 13 for convergence
    localparam int N_CL  = ITERATIONS;
    localparam int N_HYP = ITERATIONS + (ITERATIONS >= 4 ? 1 : 0) + (ITERATIONS >= 13 ? 1 : 0);
    localparam int CW    = $clog2(N_HYP + 1);
    // angle tables are Q16.16; rescale to the working fraction width
    localparam int TSH_L = FRAC_BITS >= 16 ? FRAC_BITS - 16 : 0;
    localparam int TSH_R = FRAC_BITS < 16 ? 16 - FRAC_BITS : 0;
    localparam logic [31:0] ONE = 32'(64'd1 << FRAC_BITS);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        r_state, w_next;
    logic [31:0]   r_x, r_y, r_z;
    logic [1:0]    r_mode;
    logic          r_vec;
    logic [CW-1:0] r_step;
    int            w_s;
    logic          w_accept, w_mode_ok, w_circ, w_lin, w_hyp, w_last, w_dpos, w_xsub;
    logic [4:0]    w_idx;
    logic [31:0]   w_xs, w_ys, w_ang, w_xn, w_yn, w_zn;
    function automatic logic [31:0] atan_q16(input logic [4:0] i);
        case (i)
            5'd0:    return 32'd51472;
            5'd1:    return 32'd30386;
            5'd2:    return 32'd16055;
            5'd3:    return 32'd8150;
            5'd4:    return 32'd4091;
            5'd5:    return 32'd2047;
            5'd6:    return 32'd1024;
            5'd7:    return 32'd512;
            5'd8:    return 32'd256;
            5'd9:    return 32'd128;
            5'd10:   return 32'd64;
            5'd11:   return 32'd32;
            5'd12:   return 32'd16;
            5'd13:   return 32'd8;
            5'd14:   return 32'd4;
            5'd15:   return 32'd2;
            5'd16:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction
    function automatic logic [31:0] atanh_q16(input logic [4:0] i);
        case (i)
            5'd1:    return 32'd35999;
            5'd2:    return 32'd16739;
            5'd3:    return 32'd8235;
            5'd4:    return 32'd4101;
            5'd5:    return 32'd2049;
            5'd6:    return 32'd1024;
            5'd7:    return 32'd512;
            5'd8:    return 32'd256;
            5'd9:    return 32'd128;
            5'd10:   return 32'd64;
            5'd11:   return 32'd32;
            5'd12:   return 32'd16;
            5'd13:   return 32'd8;
            5'd14:   return 32'd4;
            5'd15:   return 32'd2;
            5'd16:   return 32'd1;
            5'd17:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction
    function automatic logic [31:0] addsub(input logic [31:0] a, input logic [31:0] b, input logic sub);
        return sub ? a - b : a + b;
    endfunction
    assign w_accept  = (r_state == IDLE) && start;
    assign w_mode_ok = (mode == `CIRCULAR) || (mode == `LINEAR) || (mode == `HYPERBOLIC);
    assign w_circ    = r_mode == `CIRCULAR;
    assign w_lin     = r_mode == `LINEAR;
    assign w_hyp     = r_mode == `HYPERBOLIC;
    assign w_s       = int'(r_step);
    // hyperbolic step s maps to index s+1, minus one after each repeated index
    assign w_idx     = 5'(w_hyp ? w_s + 1 - (w_s >= 4 ? 1 : 0) - (w_s >= 14 ? 1 : 0) : w_s);
    assign w_last    = w_s == (w_hyp ? N_HYP : N_CL) - 1;
    assign w_dpos    = r_vec ? r_y[31] : ~r_z[31];
    assign w_xs      = $signed(r_x) >>> w_idx;
    assign w_ys      = $signed(r_y) >>> w_idx;
    assign w_ang     = w_circ ? (atan_q16(w_idx) << TSH_L) >> TSH_R :
                       w_lin  ? ONE >> w_idx :
                                (atanh_q16(w_idx) << TSH_L) >> TSH_R;
    // circular subtracts d*y from x, hyperbolic adds it
    assign w_xsub    = w_circ ? w_dpos : ~w_dpos;
    assign w_xn      = w_lin ? r_x : addsub(r_x, w_ys, w_xsub);
    assign w_yn      = addsub(r_y, w_xs, ~w_dpos);
    assign w_zn      = addsub(r_z, w_ang, w_dpos);
    assign busy      = r_state == RUN;
    assign done      = r_state == DONE;
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = start ? (w_mode_ok ? RUN : DONE) : IDLE;
        else if (r_state == RUN)
            w_next = w_last ? DONE : RUN;
        else
            w_next = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_mode  <= '0;
            r_vec   <= 1'b0;
            r_step  <= '0;
            x_out   <= '0;
            y_out   <= '0;
            z_out   <= '0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_x    <= x_in;
                r_y    <= y_in;
                r_z    <= z_in;
                r_mode <= mode;
                r_vec  <= vectoring;
                r_step <= '0;
                err    <= ~w_mode_ok;
                if (!w_mode_ok) begin
                    x_out <= '0;
                    y_out <= '0;
                    z_out <= '0;
                end
            end else if (r_state == RUN) begin
                r_x    <= w_xn;
                r_y    <= w_yn;
                r_z    <= w_zn;
                r_step <= r_step + CW'(1);
                if (w_last) begin
                    x_out <= w_xn;
                    y_out <= w_yn;
                    z_out <= w_zn;
                end
            end
        end
    end
`ifdef CORDIC_OVF_DETECT_EN
    logic r_ovf, w_ovf;
    function automatic logic ovf_of(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                                    input logic sub);
        return (a[31] == (b[31] ^ sub)) && (s[31] != a[31]);
    endfunction
    assign w_ovf = (!w_lin && ovf_of(r_x, w_ys, w_xn, w_xsub)) ||
                   ovf_of(r_y, w_xs, w_yn, ~w_dpos) ||
                   ovf_of(r_z, w_ang, w_zn, w_dpos);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_accept)
            r_ovf <= 1'b0;
        else if (r_state == RUN && w_ovf)
            r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: scoreboard bench for cordic_iter_engine against a behavioural CORDIC model
`ifndef CIRCULAR
`define CIRCULAR 2'd0
`endif
`ifndef LINEAR
`define LINEAR 2'd1
`endif
`ifndef HYPERBOLIC
`define HYPERBOLIC 2'd2
`endif
module tb_cordic_iter_engine;
    localparam int IT = 16;
`ifdef CORDIC_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, vectoring = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] x_in = '0, y_in = '0, z_in = '0;
    logic [31:0] x_out, y_out, z_out;
    logic        busy, done, err, ovf;
    int          cyc = 0, errors = 0, checks = 0;
    int          atan_t[25], atanh_t[25];
    logic [1:0]  bad_mode;
    typedef struct {
        logic [31:0] x, y, z;
        logic        err, ovf;
        int          cyc;
        int          nx, ny, nz, tx, ty, tz;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    cordic_iter_engine #(.ITERATIONS(IT), .FRAC_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .vectoring(vectoring),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .done(done), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input int nom, input int tol);
        longint d;
        if (tol < 0) return;
        checks++;
        d = longint'($signed(act)) - longint'(nom);
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, $signed(act), nom, tol);
        end
    endtask

    function automatic real atanh_series(input real x);
        real s = 0.0, p = x;
        for (int k = 0; k < 60; k++) begin
            s = s + p / (2.0 * k + 1.0);
            p = p * x * x;
        end
        return s;
    endfunction

    function automatic bit out32(input longint v);
        return v > 64'sd2147483647 || v < -64'sd2147483648;
    endfunction

    // iterate the update equations over the list of shift indices for the mode
    function automatic exp_t model(input logic [1:0] m, input logic v, input int x0, input int y0, input int z0);
        exp_t   e;
        int     x = x0, y = y0, z = z0, d, xs, ys, ang;
        longint nx, ny, nz;
        int     seq[$];
        bit     of = 1'b0;
        e = '{default: 0};
        if (m != `CIRCULAR && m != `LINEAR && m != `HYPERBOLIC) begin
            e.err = 1'b1;
            return e;
        end
        if (m == `HYPERBOLIC) begin
            for (int i = 1; i <= IT; i++) begin
                seq.push_back(i);
                if (i == 4 || i == 13) seq.push_back(i);
            end
        end else begin
            for (int i = 0; i < IT; i++) seq.push_back(i);
        end
        foreach (seq[k]) begin
            int i;
            i   = seq[k];
            d   = v ? (y < 0 ? 1 : -1) : (z >= 0 ? 1 : -1);
            xs  = x >>> i;
            ys  = y >>> i;
            ang = m == `CIRCULAR ? atan_t[i] : m == `LINEAR ? (65536 >>> i) : atanh_t[i];
            nx  = m == `LINEAR ? longint'(x) :
                  m == `CIRCULAR ? longint'(x) - d * longint'(ys) : longint'(x) + d * longint'(ys);
            ny  = longint'(y) + d * longint'(xs);
            nz  = longint'(z) - d * longint'(ang);
            if (out32(nx) || out32(ny) || out32(nz)) of = 1'b1;
            x = int'(nx);
            y = int'(ny);
            z = int'(nz);
        end
        e.x   = x;
        e.y   = y;
        e.z   = z;
        e.ovf = of & OVF_EN;
        e.cyc = seq.size();
        return e;
    endfunction

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while ((busy || done) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait", 32'(busy || done), 32'd0);
    endtask

    task automatic issue(input logic [1:0] m, input logic v, input int x, input int y, input int z,
                         input int nx, input int ny, input int nz, input int tx, input int ty, input int tz,
                         input bit push, output int acc);
        exp_t e;
        wait_idle();
        e     = model(m, v, x, y, z);
        acc   = cyc + 1;
        e.cyc = e.cyc + acc;
        e.nx  = nx; e.ny = ny; e.nz = nz;
        e.tx  = tx; e.ty = ty; e.tz = tz;
        start = 1'b1; mode = m; vectoring = v;
        x_in  = x; y_in = y; z_in = z;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("busy_low_at_done", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding at cycle %0d", cyc);
            end else begin
                me = sb.pop_front();
                chk("x_out", x_out, me.x);
                chk("y_out", y_out, me.y);
                chk("z_out", z_out, me.z);
                chk("err", 32'(err), 32'(me.err));
                chk("ovf", 32'(ovf), 32'(me.ovf));
                chk("done_cycle", 32'(cyc), 32'(me.cyc));
                chk_near("x_near", x_out, me.nx, me.tx);
                chk_near("y_near", y_out, me.ny, me.ty);
                chk_near("z_near", z_out, me.nz, me.tz);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, a2, n, w, r;
        exp_t e1, e2;
        logic [1:0] m;
        logic v;
        int x, y, z;
        for (int i = 0; i < 25; i++) begin
            atan_t[i]  = $rtoi($atan(2.0 ** (-i)) * 65536.0 + 0.5);
            atanh_t[i] = i == 0 ? 0 : $rtoi(atanh_series(2.0 ** (-i)) * 65536.0 + 0.5);
        end
        bad_mode = 2'd0;
        for (int c = 0; c < 4; c++)
            if (2'(c) != `CIRCULAR && 2'(c) != `LINEAR && 2'(c) != `HYPERBOLIC) bad_mode = 2'(c);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_x", x_out, 32'd0);
        chk("rst_y", y_out, 32'd0);
        chk("rst_z", z_out, 32'd0);
        reset = 1'b0;
        issue(`CIRCULAR, 1'b0, 65536, 0, 34315, 93464, 53961, 0, 32, 32, 8, 1'b1, acc);
        issue(`CIRCULAR, 1'b1, 196608, 262144, 0, 539608, 0, 60771, 64, 32, 8, 1'b1, acc);
        issue(`LINEAR, 1'b1, 131072, 98304, 0, 131072, 0, 49152, 0, -1, 8, 1'b1, acc);
        issue(`HYPERBOLIC, 1'b0, 65536, 0, 32768, 61201, 28282, 0, 64, 64, -1, 1'b1, acc);
        issue(bad_mode, 1'b0, 12345, -6789, 4242, 0, 0, 0, 0, 0, 0, 1'b1, acc);
        issue(`CIRCULAR, 1'b0, 32'h7FFF0000, 32'h7FFF0000, 0, 0, 0, 0, -1, -1, -1, 1'b1, acc);
        issue(`LINEAR, 1'b0, 98304, 1000, -40000, 0, 0, 0, -1, -1, -1, 1'b1, acc);
        // a start in the fifth cycle of an operation must be ignored
        issue(`CIRCULAR, 1'b0, 70000, -20000, 30000, 0, 0, 0, -1, -1, -1, 1'b1, acc);
        while (cyc < acc + 4) @(negedge clk);
        start = 1'b1; mode = `LINEAR; x_in = 5; y_in = 6; z_in = 7;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
        chk("no_done_after_ignored_start", 32'(done), 32'd0);
        // start held high: next accept lands in the IDLE cycle after done
        for (int k = 0; k < 2; k++) begin
            wait_idle();
            m  = k == 0 ? `HYPERBOLIC : bad_mode;
            e1 = model(m, 1'b1, 80000, 20000, 0);
            n  = e1.cyc;
            acc = cyc + 1;
            a2 = acc + n + 2;
            e1.cyc = acc + n;
            e1.tx = -1; e1.ty = -1; e1.tz = -1;
            e2 = e1;
            e2.cyc = a2 + n;
            sb.push_back(e1);
            sb.push_back(e2);
            start = 1'b1; mode = m; vectoring = 1'b1; x_in = 80000; y_in = 20000; z_in = 0;
            while (cyc < a2) @(negedge clk);
            start = 1'b0;
        end
        // reset in the eighth cycle aborts the operation without a done pulse
        issue(`CIRCULAR, 1'b0, 65536, 0, 20000, 0, 0, 0, -1, -1, -1, 1'b0, acc);
        while (cyc < acc + 7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_x", x_out, 32'd0);
        chk("mid_rst_y", y_out, 32'd0);
        chk("mid_rst_z", z_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            m = 2'($urandom_range(0, 3));
            v = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 3));
            x = r == 0 ? int'($urandom) : int'($urandom_range(0, 262143)) - 131072;
            y = r == 0 ? int'($urandom) : int'($urandom_range(0, 262143)) - 131072;
            z = r == 0 ? int'($urandom) : int'($urandom_range(0, 131071)) - 65536;
            issue(m, v, x, y, z, 0, 0, 0, -1, -1, -1, 1'b1, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
